pixel_writer: RTL and testbench
===============================

PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 Parameters, one per line:
  FB_WIDTH  320  visible columns.
  FB_HEIGHT  240  visible rows.
  FIFO_DEPTH  4  pixel buffer entries.
REQ-002 Ports, one per line:
  clk  in  1  single clock; all state on rising edge.
  reset_n  in  1  asynchronous active-low reset.
  pixel_x  in  9  pixel column from the rasteriser.
  pixel_y  in  9  pixel row from the rasteriser.
  pixel_color  in  8  pixel colour.
  pixel_valid  in  1  pixel present this cycle.
  pixel_ready  out  1  buffer can accept a pixel.
  mem_req  out  1  framebuffer write request.
  mem_addr  out  17  framebuffer word address.
  mem_wdata  out  8  framebuffer write data.
  mem_ack  in  1  framebuffer write accepted.
  busy  out  1  FIFO non-empty or write outstanding.
  overflow  out  1  sticky: a pixel was dropped.
  clip_count  out  16  count of off-screen pixels discarded.

Function
REQ-003 The design SHALL use one clock (clk); reset_n SHALL be asynchronous and active-low.
REQ-004 pixel_ready SHALL equal NOT FIFO-full, derived from registered occupancy; the design SHALL NOT push when full, even if a pop occurs in the same cycle.
REQ-005 A pixel SHALL be accepted on an edge where pixel_valid=1 and pixel_ready=1.
REQ-006 An accepted pixel with pixel_x>=FB_WIDTH or pixel_y>=FB_HEIGHT SHALL NOT enter the FIFO, and clip_count SHALL increment, saturating at 0xFFFF.
REQ-007 When pixel_valid=1 and pixel_ready=0, the pixel SHALL be dropped and overflow SHALL set; overflow SHALL clear only on reset.
REQ-008 An on-screen accepted pixel SHALL be pushed as {addr = pixel_y*FB_WIDTH + pixel_x (17-bit, unsigned), color}.
REQ-009 Write FSM states SHALL be IDLE and WRITE.
REQ-010 IDLE: if the FIFO is non-empty, the FSM SHALL pop the head, register mem_addr and mem_wdata, set mem_req=1, and go to WRITE on the same edge.
REQ-011 WRITE: mem_req, mem_addr and mem_wdata SHALL hold stable until an edge with mem_ack=1.
REQ-012 On the ack edge, if the FIFO is non-empty, the FSM SHALL pop the next entry and keep mem_req=1 (back-to-back writes, no bubble).
REQ-013 On the ack edge, if the FIFO is empty, the FSM SHALL return to IDLE with mem_req=0.
REQ-014 Latency: a pixel accepted at edge N into an empty, idle block SHALL drive mem_req=1 after edge N+1.
REQ-015 mem_ack while mem_req=0 SHALL be ignored.
REQ-016 Simultaneous push and pop in the same cycle SHALL leave occupancy unchanged and preserve FIFO order.
REQ-017 Pixel write order SHALL equal pixel acceptance order.
REQ-018 busy SHALL be 1 whenever occupancy>0 or the FSM is in WRITE.

Reset
REQ-019 While reset_n=0, the design SHALL hold: FSM=IDLE, FIFO empty, mem_req=0, mem_addr=0, mem_wdata=0, overflow=0, clip_count=0, busy=0, pixel_ready=1.
REQ-020 Reset asserted mid-write SHALL abandon the outstanding request and discard FIFO contents immediately (asynchronous).

Structure
REQ-021 FB_WIDTH, FB_HEIGHT, the address width (17), the pixel coordinate width (9), the colour width (8) and the FSM state enum SHALL reside in a shared gpu_pkg package.
REQ-022 The FIFO SHALL be a separate sub-module, pixel_fifo (parameterised depth and width), instantiated once.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
  - Single pixel (5,5) colour 0xFF, mem_ack tied 1 -> mem_req=1 after edge N+1 with mem_addr=1605, mem_wdata=0xFF; busy=0 two cycles later.
  - Line (0,0)-(5,5) streamed with mem_ack always 1 -> six writes, addresses 0, 321, 642, 963, 1284, 1605, with back-to-back mem_req.
  - mem_ack held 0 while 6 pixels are presented -> pixel_ready=0 after 4 accepted (+1 in flight); remaining pixel dropped; overflow=1; order preserved once ack resumes.
  - Pixels (320,0) and (0,240) -> no mem_req; clip_count=2.
  - Pixel (319,239) -> mem_addr=76799.
  - reset_n pulsed low while in WRITE with 3 queued pixels -> mem_req=0 immediately; after release, no writes occur, and all outputs match their reset values.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared framebuffer geometry, field widths and write-FSM types for the pixel path.
package gpu_pkg;

    localparam int FB_WIDTH   = 320;
    localparam int FB_HEIGHT  = 240;
    localparam int ADDR_W     = 17;
    localparam int COORD_W    = 9;
    localparam int COLOR_W    = 8;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wr_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } pix_entry_t;

    // Linear word address of an on-screen pixel; the caller guarantees x<width, y<height.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] y,
                                                     input int width);
        return ADDR_W'(y) * ADDR_W'(width) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO with registered occupancy; push is refused when full
// regardless of a same-cycle pop, so full/ready never depends on the pop path.
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 25
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_writer.sv
// Clips rasteriser pixels, buffers on-screen ones and streams them to the
// framebuffer through a req/ack write port with back-to-back issue.
module pixel_writer #(
    parameter int FB_WIDTH   = gpu_pkg::FB_WIDTH,
    parameter int FB_HEIGHT  = gpu_pkg::FB_HEIGHT,
    parameter int FIFO_DEPTH = gpu_pkg::FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [gpu_pkg::COORD_W-1:0] pixel_x,
    input  logic [gpu_pkg::COORD_W-1:0] pixel_y,
    input  logic [gpu_pkg::COLOR_W-1:0] pixel_color,
    input  logic                        pixel_valid,
    output logic                        pixel_ready,
    output logic                        mem_req,
    output logic [gpu_pkg::ADDR_W-1:0]  mem_addr,
    output logic [gpu_pkg::COLOR_W-1:0] mem_wdata,
    input  logic                        mem_ack,
    output logic                        busy,
    output logic                        overflow,
    output logic [15:0]                 clip_count
);

    import gpu_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    wr_state_t        state;
    pix_entry_t       push_entry;
    pix_entry_t       head;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] occupancy;
    logic             accept;
    logic             on_screen;
    logic             push;
    logic             pop;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign pixel_ready = ~fifo_full;
    assign accept      = pixel_valid & pixel_ready;
    assign on_screen   = (int'(pixel_x) < FB_WIDTH) && (int'(pixel_y) < FB_HEIGHT);
    assign push        = accept & on_screen;
    assign push_entry  = '{addr: pixel_addr(pixel_x, pixel_y, FB_WIDTH), color: pixel_color};
    // An ack only matters while a request is outstanding, i.e. in WRITE.
    assign pop         = ~fifo_empty & ((state == IDLE) | mem_ack);
    assign busy        = (occupancy != '0) || (state == WRITE);

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(pix_entry_t))
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (occupancy)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        mem_addr  <= head.addr;
                        mem_wdata <= head.color;
                        mem_req   <= 1'b1;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        if (!fifo_empty) begin
                            mem_addr  <= head.addr;
                            mem_wdata <= head.color;
                        end else begin
                            mem_req <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            clip_count <= '0;
        end else begin
            if (pixel_valid && !pixel_ready) begin
                overflow <= 1'b1;
            end
            if (accept && !on_screen) begin
                clip_count <= sat_inc16(clip_count);
            end
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: latency, streaming, backpressure, clipping,
// corner address and asynchronous reset during a write.
module tb_pixel_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [8:0]  pixel_x;
    logic [8:0]  pixel_y;
    logic [7:0]  pixel_color;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic        busy;
    logic        overflow;
    logic [15:0] clip_count;

    int errors = 0;
    int checks = 0;
    logic [24:0] writes[$];

    always #5 clk = ~clk;

    pixel_writer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_color (pixel_color),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .busy        (busy),
        .overflow    (overflow),
        .clip_count  (clip_count)
    );

    // Completed writes: req and ack both high ahead of the next rising edge.
    always @(negedge clk) begin
        if (reset_n && mem_req && mem_ack) begin
            writes.push_back({mem_addr, mem_wdata});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x, input int y, input int c);
        pixel_x     = 9'(x);
        pixel_y     = 9'(y);
        pixel_color = 8'(c);
        pixel_valid = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},   32'(mem_req), 0);
        check({tag, "_addr"},  32'(mem_addr), 0);
        check({tag, "_wdata"}, 32'(mem_wdata), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_ready"}, 32'(pixel_ready), 1);
        check({tag, "_ovf"},   32'(overflow), 0);
        check({tag, "_clip"},  32'(clip_count), 0);
    endtask

    initial begin
        int   first;
        int   last;
        int   nreq;
        logic rdy [6];

        reset_n     = 1'b0;
        pixel_valid = 1'b0;
        pixel_x     = '0;
        pixel_y     = '0;
        pixel_color = '0;
        mem_ack     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        reset_n = 1'b1;
        step();

        // Single pixel, ack tied high
        writes.delete();
        mem_ack = 1'b1;
        drive(5, 5, 8'hFF);
        step();
        pixel_valid = 1'b0;
        check("t1_req_at_N", 32'(mem_req), 0);
        step();
        check("t1_req_N1", 32'(mem_req), 1);
        check("t1_addr", 32'(mem_addr), 1605);
        check("t1_wdata", 32'(mem_wdata), 32'hFF);
        check("t1_busy_mid", 32'(busy), 1);
        step();
        check("t1_req_done", 32'(mem_req), 0);
        check("t1_busy_done", 32'(busy), 0);
        check("t1_nwrites", writes.size(), 1);

        // Diagonal line streamed with ack always high
        writes.delete();
        first = -1;
        last  = -1;
        nreq  = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 6) drive(i, i, i);
            else pixel_valid = 1'b0;
            step();
            if (mem_req) begin
                nreq++;
                if (first < 0) first = i;
                last = i;
            end
        end
        check("t2_req_cycles", nreq, 6);
        check("t2_req_span", last - first + 1, 6);
        check("t2_nwrites", writes.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < writes.size()) begin
                check("t2_addr", 32'(writes[k][24:8]), k * 321);
                check("t2_wdata", 32'(writes[k][7:0]), k);
            end
        end

        // Backpressure: ack held low while six pixels are offered
        writes.delete();
        mem_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(10 + i, 1, 8'h10 + i);
            rdy[i] = pixel_ready;
            step();
        end
        pixel_valid = 1'b0;
        check("t3_ready_4th", 32'(rdy[4]), 1);
        check("t3_ready_5th", 32'(rdy[5]), 0);
        check("t3_ready_full", 32'(pixel_ready), 0);
        check("t3_overflow", 32'(overflow), 1);
        check("t3_req_held", 32'(mem_req), 1);
        step();
        step();
        check("t3_addr_stable", 32'(mem_addr), 330);
        check("t3_wdata_stable", 32'(mem_wdata), 32'h10);
        check("t3_busy", 32'(busy), 1);
        mem_ack = 1'b1;
        repeat (10) step();
        check("t3_nwrites", writes.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < writes.size()) begin
                check("t3_order_addr", 32'(writes[k][24:8]), 330 + k);
                check("t3_order_wdata", 32'(writes[k][7:0]), 32'h10 + k);
            end
        end
        check("t3_ready_after", 32'(pixel_ready), 1);
        check("t3_busy_after", 32'(busy), 0);
        check("t3_ovf_sticky", 32'(overflow), 1);

        // Off-screen pixels are clipped
        writes.delete();
        nreq = 0;
        drive(320, 0, 1);
        step();
        drive(0, 240, 2);
        step();
        pixel_valid = 1'b0;
        repeat (4) begin
            step();
            if (mem_req) nreq++;
        end
        check("t4_no_req", nreq, 0);
        check("t4_nwrites", writes.size(), 0);
        check("t4_clip", 32'(clip_count), 2);
        check("t4_busy", 32'(busy), 0);

        // Bottom-right corner
        drive(319, 239, 8'h5A);
        step();
        pixel_valid = 1'b0;
        step();
        check("t5_req", 32'(mem_req), 1);
        check("t5_addr", 32'(mem_addr), 76799);
        check("t5_wdata", 32'(mem_wdata), 32'h5A);
        step();
        check("t5_req_done", 32'(mem_req), 0);

        // Reset asserted mid-write with three pixels queued
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(20 + i, 2, i);
            step();
        end
        pixel_valid = 1'b0;
        check("t6_req_before", 32'(mem_req), 1);
        check("t6_busy_before", 32'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("t6_async");
        #3;
        reset_n = 1'b1;
        writes.delete();
        mem_ack = 1'b1;
        nreq    = 0;
        repeat (6) begin
            step();
            if (mem_req) nreq++;
        end
        check("t6_no_req", nreq, 0);
        check("t6_nwrites", writes.size(), 0);
        check_reset_values("t6_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
